// File: rtl/l2bank_arb.sv
// l2bank_arb: shares the four-bank L2 data array between the request stream
// and the snoop stream. A burst winner owns the banks for all 8 beats; read
// beats are routed back to their owner a fixed BANK_LAT cycles after issue.
// Optional performance counters are enabled with `define L2BANK_ARB_PERF_EN.
module l2bank_arb #(
  parameter int STARVE_LIMIT = 8,
  parameter int BANK_LAT     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_burst,
  input  logic         req_wen,
  input  logic [3:0]   req_way,
  input  logic [11:0]  req_addr,
  input  logic [7:0]   req_wmask,
  input  logic [63:0]  req_wdata,
  output logic         req_beat_ready,
  output logic         req_done,
  input  logic         resp_stall,
  input  logic         snp_valid,
  input  logic         snp_wen,
  input  logic [3:0]   snp_way,
  input  logic [8:0]   snp_set,
  input  logic [63:0]  snp_wdata,
  output logic         snp_beat_ready,
  output logic         snp_done,
  output logic [3:0]   bank_valid,
  output logic         bank_wen,
  output logic [11:0]  bank_addr,
  output logic [7:0]   bank_wmask,
  output logic [63:0]  bank_wdata,
  input  logic [255:0] bank_rdata,
  output logic         rd_req_valid,
  output logic         rd_snp_valid,
  output logic [63:0]  rd_data
`ifdef L2BANK_ARB_PERF_EN
  ,
  output logic [31:0]  perf_req_beats,
  output logic [31:0]  perf_snp_beats,
  output logic [31:0]  perf_conflict_cycles
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ_BURST = 2'd1;
  localparam logic [1:0] SNP_BURST = 2'd2;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state;
  logic [2:0]    beat;
  logic [SW-1:0] starve_cnt;

  // Return pipeline entry: {valid, owner is snoop, bank index}
  logic [3:0] ret_sr [BANK_LAT];
  logic [3:0] ret_head;

  logic       idle;
  logic       req_elig;
  logic       issue_req;
  logic       issue_snp;
  logic       any_issue;
  logic       single;
  logic [2:0] cur_beat;
  logic [1:0] bank_sel;
  logic       half_sel;
  logic [3:0] way_sel;
  logic [1:0] way_idx;
  logic [8:0] set_sel;
  logic       wen_sel;

  // Grant and issue decision; everything is held off while reset is asserted
  always_comb begin
    idle      = (state == IDLE);
    req_elig  = req_valid & (req_wen | ~resp_stall);
    issue_req = 1'b0;
    issue_snp = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          // a starved eligible request beats a waiting snoop
          issue_snp = snp_valid & ~(req_elig & (starve_cnt == STARVE_MAX));
          issue_req = req_elig & ~issue_snp;
        end
        REQ_BURST: issue_req = req_elig;
        SNP_BURST: issue_snp = snp_valid;
        default: ;
      endcase
    end
  end

  // Beat-to-bank mapping and bank-side datapath for the issuing stream
  always_comb begin
    any_issue = issue_req | issue_snp;
    single    = idle & ~req_burst & issue_req;
    cur_beat  = idle ? 3'd0 : beat;
    bank_sel  = single ? req_addr[1:0] : cur_beat[1:0];
    half_sel  = single ? req_addr[2] : cur_beat[2];
    way_sel   = issue_snp ? snp_way : req_way;
    set_sel   = issue_snp ? snp_set : req_addr[11:3];
    wen_sel   = issue_snp ? snp_wen : req_wen;
    way_idx   = {way_sel[3] | way_sel[2], way_sel[3] | way_sel[1]};

    bank_valid = any_issue ? (4'b0001 << bank_sel) : 4'b0000;
    bank_wen   = any_issue & wen_sel;
    bank_addr  = any_issue ? {way_idx, set_sel, half_sel} : 12'h000;
    bank_wmask = !any_issue ? 8'h00 : (single ? req_wmask : 8'hFF);
    bank_wdata = !any_issue ? 64'h0 : (issue_snp ? snp_wdata : req_wdata);

    req_beat_ready = issue_req;
    snp_beat_ready = issue_snp;
    req_done       = issue_req & (single | ((state == REQ_BURST) & (beat == 3'd7)));
    snp_done       = issue_snp & (state == SNP_BURST) & (beat == 3'd7);
  end

  // Burst ownership and beat sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_snp) begin
            state <= SNP_BURST;
            beat  <= 3'd1;
          end else if (issue_req & req_burst) begin
            state <= REQ_BURST;
            beat  <= 3'd1;
          end
        end
        REQ_BURST, SNP_BURST: begin
          if (any_issue) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter: counts cycles a waiting request is passed over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (idle & issue_req) begin
      starve_cnt <= '0;
    end else if (req_valid & (state != REQ_BURST) & (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Fixed-latency read return pipeline tracking owner and bank of each read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BANK_LAT; i++) ret_sr[i] <= 4'h0;
    end else begin
      ret_sr[0] <= {any_issue & ~wen_sel, issue_snp, bank_sel};
      for (int i = 1; i < BANK_LAT; i++) ret_sr[i] <= ret_sr[i-1];
    end
  end

  // Head of the pipeline selects the returning bank slice
  always_comb begin
    ret_head     = ret_sr[BANK_LAT-1];
    rd_req_valid = ret_head[3] & ~ret_head[2];
    rd_snp_valid = ret_head[3] & ret_head[2];
    rd_data      = ret_head[3] ? bank_rdata[{ret_head[1:0], 6'd0} +: 64] : 64'h0;
  end

`ifdef L2BANK_ARB_PERF_EN
  // Per-stream beat counts and IDLE contention cycles, free-running and wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_beats       <= 32'd0;
      perf_snp_beats       <= 32'd0;
      perf_conflict_cycles <= 32'd0;
    end else begin
      if (issue_req) perf_req_beats <= perf_req_beats + 32'd1;
      if (issue_snp) perf_snp_beats <= perf_snp_beats + 32'd1;
      if (idle & req_valid & snp_valid) perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2bank_arb.sv
// Testbench for l2bank_arb: directed test-plan steps followed by random
// traffic, all checked every cycle against a transaction-level reference.
module tb_l2bank_arb;
  localparam int STARVE_LIMIT = 8;
  localparam int BANK_LAT     = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 0, req_burst = 0, req_wen = 0;
  logic [3:0]   req_way = 4'b0001;
  logic [11:0]  req_addr = 0;
  logic [7:0]   req_wmask = 0;
  logic [63:0]  req_wdata = 0;
  logic         req_beat_ready, req_done;
  logic         resp_stall = 0;
  logic         snp_valid = 0, snp_wen = 0;
  logic [3:0]   snp_way = 4'b0001;
  logic [8:0]   snp_set = 0;
  logic [63:0]  snp_wdata = 0;
  logic         snp_beat_ready, snp_done;
  logic [3:0]   bank_valid;
  logic         bank_wen;
  logic [11:0]  bank_addr;
  logic [7:0]   bank_wmask;
  logic [63:0]  bank_wdata;
  logic [255:0] bank_rdata = '0;
  logic         rd_req_valid, rd_snp_valid;
  logic [63:0]  rd_data;
`ifdef L2BANK_ARB_PERF_EN
  logic [31:0]  perf_req_beats, perf_snp_beats, perf_conflict_cycles;
`endif

  always #5 clk = ~clk;

  l2bank_arb #(.STARVE_LIMIT(STARVE_LIMIT), .BANK_LAT(BANK_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_burst(req_burst), .req_wen(req_wen), .req_way(req_way),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .req_beat_ready(req_beat_ready), .req_done(req_done), .resp_stall(resp_stall),
    .snp_valid(snp_valid), .snp_wen(snp_wen), .snp_way(snp_way), .snp_set(snp_set),
    .snp_wdata(snp_wdata), .snp_beat_ready(snp_beat_ready), .snp_done(snp_done),
    .bank_valid(bank_valid), .bank_wen(bank_wen), .bank_addr(bank_addr),
    .bank_wmask(bank_wmask), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .rd_req_valid(rd_req_valid), .rd_snp_valid(rd_snp_valid), .rd_data(rd_data)
`ifdef L2BANK_ARB_PERF_EN
    , .perf_req_beats(perf_req_beats), .perf_snp_beats(perf_snp_beats),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct { int due; bit snp; int bank; } ret_t;
  ret_t rq[$];
  int cyc = 0;
  int m_owner = 0;   // 0 nobody, 1 request burst, 2 snoop burst
  int m_beat = 0;
  int m_starve = 0;
  int m_req_beats = 0, m_snp_beats = 0;

  int          e_issue;   // 0 none, 1 request, 2 snoop
  bit          e_single;
  int          e_bank, e_half, e_beat;
  bit          e_wen;
  logic [11:0] e_addr;
  logic [7:0]  e_mask;
  logic [63:0] e_wdata;
  bit          e_req_done, e_snp_done, e_rd, e_rd_snp;
  logic [63:0] e_rd_data;

  function automatic int way_index(input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_beat = 0; m_starve = 0;
    m_req_beats = 0; m_snp_beats = 0;
    rq.delete();
  endtask

  task automatic model_comb();
    bit elig;
    int way, set;
    elig = req_valid && (req_wen || !resp_stall);
    e_issue = 0; e_single = 0;
    if (rst) begin
      if (m_owner == 0) begin
        if (snp_valid && !(elig && m_starve == STARVE_LIMIT)) e_issue = 2;
        else if (elig) begin e_issue = 1; e_single = !req_burst; end
      end else if (m_owner == 1) begin
        if (elig) e_issue = 1;
      end else if (snp_valid) e_issue = 2;
    end
    e_beat = (m_owner == 0) ? 0 : m_beat;
    if (e_single) begin
      e_bank = int'(req_addr) % 4; e_half = (int'(req_addr) / 4) % 2;
    end else begin
      e_bank = e_beat % 4; e_half = e_beat / 4;
    end
    if (e_issue == 2) begin
      way = way_index(snp_way); set = int'(snp_set); e_wen = snp_wen;
      e_mask = 8'hFF; e_wdata = snp_wdata;
    end else begin
      way = way_index(req_way); set = int'(req_addr) / 8; e_wen = req_wen;
      e_mask = e_single ? req_wmask : 8'hFF; e_wdata = req_wdata;
    end
    e_addr = 12'(way * 1024 + set * 2 + e_half);
    e_req_done = (e_issue == 1) && (e_single || e_beat == 7);
    e_snp_done = (e_issue == 2) && (e_beat == 7);
    e_rd = (rq.size() > 0) && (rq[0].due == cyc);
    e_rd_snp = e_rd && rq[0].snp;
    e_rd_data = e_rd ? 64'(bank_rdata >> (64 * rq[0].bank)) : 64'h0;
  endtask

  task automatic model_seq();
    if (e_issue != 0 && !e_wen) rq.push_back('{due: cyc + BANK_LAT, snp: (e_issue == 2), bank: e_bank});
    if (e_rd) void'(rq.pop_front());
    if (e_issue == 1) m_req_beats++;
    if (e_issue == 2) m_snp_beats++;
    if (m_owner == 0 && e_issue == 1) m_starve = 0;
    else if (req_valid && m_owner != 1 && m_starve < STARVE_LIMIT) m_starve++;
    if (m_owner == 0) begin
      if (e_issue == 2) begin m_owner = 2; m_beat = 1; end
      else if (e_issue == 1 && !e_single) begin m_owner = 1; m_beat = 1; end
    end else if (e_issue != 0) begin
      if (m_beat == 7) begin m_owner = 0; m_beat = 0; end
      else m_beat++;
    end
    cyc++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("bank_valid", 64'(bank_valid), (e_issue != 0) ? (64'd1 << e_bank) : 64'd0);
    chk("req_beat_ready", 64'(req_beat_ready), 64'(e_issue == 1));
    chk("snp_beat_ready", 64'(snp_beat_ready), 64'(e_issue == 2));
    chk("req_done", 64'(req_done), 64'(e_req_done));
    chk("snp_done", 64'(snp_done), 64'(e_snp_done));
    if (e_issue != 0) begin
      chk("bank_wen", 64'(bank_wen), 64'(e_wen));
      chk("bank_addr", 64'(bank_addr), 64'(e_addr));
      chk("bank_wmask", 64'(bank_wmask), 64'(e_mask));
      if (e_wen) chk("bank_wdata", bank_wdata, e_wdata);
    end
    chk("rd_req_valid", 64'(rd_req_valid), 64'(e_rd && !e_rd_snp));
    chk("rd_snp_valid", 64'(rd_snp_valid), 64'(e_rd_snp));
    if (e_rd) chk("rd_data", rd_data, e_rd_data);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bank_valid"}, 64'(bank_valid), 64'd0);
    chk({tag, "_bank_addr"}, 64'({bank_wen, bank_addr, bank_wmask}), 64'd0);
    chk({tag, "_bank_wdata"}, bank_wdata, 64'd0);
    chk({tag, "_hs"}, 64'({req_beat_ready, req_done, snp_beat_ready, snp_done}), 64'd0);
    chk({tag, "_rd"}, 64'({rd_req_valid, rd_snp_valid}), 64'd0);
    chk({tag, "_rd_data"}, rd_data, 64'd0);
  endtask

  // settle: inputs are driven; check outputs. advance: clock edge + model update.
  task automatic settle();
    for (int i = 0; i < 8; i++) bank_rdata[i*32 +: 32] = $urandom;
    #1;
    model_comb();
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  int bv_t1 [8]  = '{1, 2, 4, 8, 1, 2, 4, 8};
  int bv_t5 [10] = '{1, 2, 4, 0, 0, 8, 1, 2, 4, 8};

  initial begin
    int pulses;

    // Reset: outputs held at zero even with both streams requesting
    req_valid = 1; snp_valid = 1; req_wen = 1;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    req_valid = 0; snp_valid = 0; req_wen = 0;
    @(negedge clk);
    rst = 1; model_reset();
    step();

    // Request read burst, way 0100, set 0x0A5
    req_way = 4'b0100; req_addr = 12'h528; req_burst = 1; req_wen = 0;
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8);
      settle();
      if (c < 8) begin
        chk("t1_bank_valid", 64'(bank_valid), 64'(bv_t1[c]));
        chk("t1_bank_addr", 64'(bank_addr), (c < 4) ? 64'h94A : 64'h94B);
        chk("t1_req_done", 64'(req_done), 64'(c == 7));
      end
      if (rd_req_valid) pulses++;
      advance();
    end
    chk("t1_rd_pulses", 64'(pulses), 64'd8);

    // Single-beat write to bank 2, half 1 with partial mask
    req_valid = 1; req_burst = 0; req_wen = 1; req_way = 4'b0001;
    req_addr = 12'h006; req_wmask = 8'h0F; req_wdata = 64'h0123_4567_89AB_CDEF;
    settle();
    chk("t2_bank_valid", 64'(bank_valid), 64'h4);
    chk("t2_wen_mask", 64'({bank_wen, bank_wmask}), 64'h10F);
    chk("t2_req_done", 64'(req_done), 64'd1);
    advance();
    req_valid = 0;
    step();

    // Simultaneous request and snoop bursts: snoop first, request right after
    req_valid = 1; req_burst = 1; req_wen = 0; req_way = 4'b1000; req_addr = 12'h3F8;
    snp_valid = 1; snp_wen = 0; snp_way = 4'b0010; snp_set = 9'h155;
    for (int c = 0; c < 16; c++) begin
      snp_valid = (c < 8);
      settle();
      chk("t3_owner", 64'({snp_beat_ready, req_beat_ready}), (c < 8) ? 64'h2 : 64'h1);
      advance();
    end
    req_valid = 0;
    repeat (3) step();

    // Starvation: request waits out one snoop burst, then wins against snp_valid
    req_valid = 1; req_burst = 1; req_wen = 1; snp_valid = 1; snp_wen = 1;
    for (int c = 0; c < 24; c++) begin
      req_valid = (c <= 16);
      req_wdata = {$urandom, $urandom}; snp_wdata = {$urandom, $urandom};
      settle();
      if (c == 8) chk("t4_starved_grant", 64'({snp_beat_ready, req_beat_ready}), 64'h1);
      if (c == 16) chk("t4_snoop_after", 64'({snp_beat_ready, req_beat_ready}), 64'h2);
      advance();
    end
    snp_valid = 0; req_valid = 0;
    step();

    // Request read burst with resp_stall at beats 3-4
    req_valid = 1; req_burst = 1; req_wen = 0; req_way = 4'b0010; req_addr = 12'h0A8;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 10);
      resp_stall = (c == 3 || c == 4);
      settle();
      if (c < 10) begin
        chk("t5_bank_valid", 64'(bank_valid), 64'(bv_t5[c]));
        chk("t5_req_done", 64'(req_done), 64'(c == 9));
      end
      advance();
    end
    resp_stall = 0;

    // Reset at beat 5 of a snoop read-out
    snp_valid = 1; snp_wen = 0; snp_way = 4'b0100; snp_set = 9'h0F0;
    for (int c = 0; c < 5; c++) step();
    settle();
    chk("t6_beat5", 64'(bank_valid), 64'h2);
    rst = 0;
    #1 chk_zero("t6_rst");
    model_reset();
    @(negedge clk);
    #1 chk_zero("t6_hold");
    rst = 1; snp_valid = 0;
    req_valid = 1; req_burst = 0; req_wen = 0; req_addr = 12'h00D;
    settle();
    chk("t6_regrant", 64'(req_beat_ready), 64'd1);
    advance();
    req_valid = 0;
    repeat (3) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (m_owner != 1) begin
        req_burst = $urandom_range(0, 1); req_wen = $urandom_range(0, 1);
        req_way = 4'b0001 << $urandom_range(0, 3);
        req_addr = 12'($urandom); req_wmask = 8'($urandom);
      end
      if (m_owner != 2) begin
        snp_wen = $urandom_range(0, 1); snp_way = 4'b0001 << $urandom_range(0, 3);
        snp_set = 9'($urandom);
      end
      req_valid = ($urandom_range(0, 9) < 7);
      snp_valid = ($urandom_range(0, 9) < 4);
      resp_stall = ($urandom_range(0, 3) == 0);
      req_wdata = {$urandom, $urandom}; snp_wdata = {$urandom, $urandom};
      step();
    end

`ifdef L2BANK_ARB_PERF_EN
    chk("perf_req_beats", 64'(perf_req_beats), 64'(m_req_beats));
    chk("perf_snp_beats", 64'(perf_snp_beats), 64'(m_snp_beats));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
